// File: rtl/spi_slave_regfile.sv
// SPI target decoding LSB-first {address, data} byte pairs into a small register file.
// SPI pins are oversampled on pclk_i; miso returns the old entry content during each data byte.
module spi_slave_regfile #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       pclk_i,
  input  logic       prst_i,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       wr_valid_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       abort_o,
  input  logic [2:0] rd_addr_i,
  output logic [7:0] rd_data_o
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    ADDR = 3'b010,
    DATA = 3'b100
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_d, cs_d;
  logic                   rise, fall, cs_rise, cs_fall, active;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] addr_sr, data_sr, miso_sr;
  logic [7:0] data_next;
  logic [7:0] regfile [DEPTH];

  logic sample_addr, sample_data, addr_done, data_done, shift_miso, abort_d;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_d;
  assign fall      = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign active    = ~cs_s;
  assign data_next = {mosi_s, data_sr[6:0]};
  assign rd_data_o = regfile[rd_addr_i];

  // The cs chain resets low so a select already held across reset never
  // looks like a fresh falling edge; the frame is ignored until cs cycles.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sample_addr = 1'b0;
    sample_data = 1'b0;
    addr_done   = 1'b0;
    data_done   = 1'b0;
    shift_miso  = 1'b0;
    abort_d     = 1'b0;
    if (cs_rise) begin
      // Deselect beats a same-cycle sclk rise; that bit is dropped.
      state_d = IDLE;
      cnt_d   = 3'd0;
      abort_d = (state_q != IDLE) && ((cnt_q != 3'd0) || (state_q == DATA));
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d = ADDR;
            cnt_d   = 3'd0;
          end
        end
        ADDR: begin
          if (active && rise) begin
            sample_addr = 1'b1;
            cnt_d       = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              addr_done = 1'b1;
              state_d   = DATA;
            end
          end
        end
        DATA: begin
          if (active && rise) begin
            sample_data = 1'b1;
            cnt_d       = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              data_done = 1'b1;
              state_d   = ADDR;
            end
          end else if (active && fall && (cnt_q != 3'd0)) begin
            // The fall between the address and data bytes keeps bit 0 on
            // the line; later falls advance to the bit the host samples next.
            shift_miso = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  // NOTE: the register file is reset like any other flop because reset must
  // clear every entry; this keeps it out of RAM macros, which is fine at this size.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      addr_sr    <= 8'd0;
      data_sr    <= 8'd0;
      miso_sr    <= 8'd0;
      miso_o     <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= 8'd0;
      wr_data_o  <= 8'd0;
      abort_o    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regfile[i] <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      abort_o    <= abort_d;
      wr_valid_o <= data_done;
      if (sample_addr) addr_sr[cnt_q] <= mosi_s;
      if (sample_data) data_sr[cnt_q] <= mosi_s;
      if (addr_done) begin
        miso_sr <= regfile[addr_sr[IDX_W-1:0]];
        miso_o  <= regfile[addr_sr[IDX_W-1:0]][0];
      end
      if (shift_miso) miso_o <= miso_sr[cnt_q];
      if (data_done) begin
        wr_addr_o                    <= addr_sr;
        wr_data_o                    <= data_next;
        regfile[addr_sr[IDX_W-1:0]] <= data_next;
      end
      if (state_d != DATA) miso_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: drives LSB-first SPI frames and checks
// commits, aborts, miso readback and the debug read port against fixed values.
module tb_spi_slave_regfile;

  logic       pclk = 1'b0;
  logic       prst;
  logic       sclk, cs_n, mosi;
  logic       miso, wr_valid, abort;
  logic [7:0] wr_addr, wr_data, rd_data;
  logic [2:0] rd_addr;

  int tests  = 0;
  int failed = 0;

  int         wr_total    = 0;
  int         abort_total = 0;
  logic [7:0] wa_log [0:63];
  logic [7:0] wd_log [0:63];

  spi_slave_regfile dut (
    .pclk_i    (pclk),
    .prst_i    (prst),
    .sclk_i    (sclk),
    .cs_n_i    (cs_n),
    .mosi_i    (mosi),
    .miso_o    (miso),
    .wr_valid_o(wr_valid),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .abort_o   (abort),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always #5 pclk = ~pclk;

  // Pulses are counted per cycle high, so a stretched pulse counts twice.
  always @(negedge pclk) begin
    if (wr_valid) begin
      if (wr_total < 64) begin
        wa_log[wr_total] <= wr_addr;
        wd_log[wr_total] <= wr_data;
      end
      wr_total <= wr_total + 1;
    end
    if (abort) abort_total <= abort_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Shifts nbits of tx LSB first; rx captures miso just before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[i];
      wait_clk(5);
      rx[i] = miso;
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d, output logic [7:0] rx_a,
                       output logic [7:0] rx_d);
    cs_n = 1'b0;
    wait_clk(5);
    spi_bits(a, 8, rx_a);
    spi_bits(d, 8, rx_d);
    wait_clk(5);
    cs_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic check_entry(input string tag, input logic [2:0] idx, input logic [7:0] exp);
    rd_addr = idx;
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    logic [7:0] rx_a, rx_d;
    int wb, ab;

    prst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; rd_addr = 3'd0;
    wait_clk(5);
    check("rst_miso", miso, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_abort", abort, 0);
    prst = 1'b0;
    wait_clk(10);
    for (int i = 0; i < 8; i++) check_entry("rst_entry", 3'(i), 8'h00);

    // Single pair
    wb = wr_total; ab = abort_total;
    frame(8'hD3, 8'h46, rx_a, rx_d);
    check("single_wr_count", wr_total - wb, 1);
    check("single_wr_addr", wa_log[wb], 8'hD3);
    check("single_wr_data", wd_log[wb], 8'h46);
    check_entry("single_entry3", 3'd3, 8'h46);
    check("single_no_abort", abort_total - ab, 0);
    check("single_miso_old", rx_d, 8'h00);

    // Burst of three pairs in one select
    wb = wr_total; ab = abort_total;
    cs_n = 1'b0;
    wait_clk(5);
    spi_bits(8'hD3, 8, rx_a); spi_bits(8'h46, 8, rx_d);
    spi_bits(8'hD4, 8, rx_a); spi_bits(8'h47, 8, rx_d);
    spi_bits(8'hD5, 8, rx_a); spi_bits(8'h48, 8, rx_d);
    wait_clk(5);
    cs_n = 1'b1;
    wait_clk(10);
    check("burst_wr_count", wr_total - wb, 3);
    check("burst_addr0", wa_log[wb], 8'hD3);
    check("burst_data0", wd_log[wb], 8'h46);
    check("burst_addr1", wa_log[wb+1], 8'hD4);
    check("burst_data1", wd_log[wb+1], 8'h47);
    check("burst_addr2", wa_log[wb+2], 8'hD5);
    check("burst_data2", wd_log[wb+2], 8'h48);
    check("burst_no_abort", abort_total - ab, 0);
    check_entry("burst_e3", 3'd3, 8'h46);
    check_entry("burst_e4", 3'd4, 8'h47);
    check_entry("burst_e5", 3'd5, 8'h48);
    check_entry("burst_e0", 3'd0, 8'h00);
    check_entry("burst_e1", 3'd1, 8'h00);
    check_entry("burst_e2", 3'd2, 8'h00);
    check_entry("burst_e6", 3'd6, 8'h00);
    check_entry("burst_e7", 3'd7, 8'h00);

    // Overwrite: miso returns old content 0x46 during the data byte
    frame(8'hD3, 8'h55, rx_a, rx_d);
    check("readback_miso", rx_d, 8'h46);
    check("readback_addr_miso_zero", rx_a, 8'h00);
    check_entry("readback_e3", 3'd3, 8'h55);

    // Aliasing: upper address bits ignored for the index
    wb = wr_total;
    frame(8'h0B, 8'hA5, rx_a, rx_d);
    check("alias_miso_old", rx_d, 8'h55);
    check("alias_wr_addr", wa_log[wb], 8'h0B);
    check("alias_wr_data", wd_log[wb], 8'hA5);
    check_entry("alias_e3", 3'd3, 8'hA5);

    // Abort after five address bits
    wb = wr_total; ab = abort_total;
    cs_n = 1'b0;
    wait_clk(5);
    spi_bits(8'hD6, 5, rx_a);
    wait_clk(5);
    cs_n = 1'b1;
    wait_clk(10);
    check("abort_count", abort_total - ab, 1);
    check("abort_no_wr", wr_total - wb, 0);
    check_entry("abort_e3", 3'd3, 8'hA5);
    check_entry("abort_e6", 3'd6, 8'h00);
    wb = wr_total; ab = abort_total;
    frame(8'hD6, 8'h49, rx_a, rx_d);
    check("post_abort_wr_count", wr_total - wb, 1);
    check("post_abort_no_abort", abort_total - ab, 0);
    check_entry("post_abort_e6", 3'd6, 8'h49);

    // Reset in the middle of the data byte
    wb = wr_total; ab = abort_total;
    cs_n = 1'b0;
    wait_clk(5);
    spi_bits(8'hD7, 8, rx_a);
    spi_bits(8'h4A, 4, rx_d);
    prst = 1'b1;
    wait_clk(3);
    prst = 1'b0;
    spi_bits(8'h04, 4, rx_d);
    wait_clk(5);
    cs_n = 1'b1;
    wait_clk(10);
    check("rst_mid_no_wr", wr_total - wb, 0);
    check("rst_mid_no_abort", abort_total - ab, 0);
    for (int i = 0; i < 8; i++) check_entry("rst_mid_entry", 3'(i), 8'h00);
    wb = wr_total;
    frame(8'hD7, 8'h4A, rx_a, rx_d);
    check("reselect_wr_count", wr_total - wb, 1);
    check("reselect_wr_addr", wa_log[wb], 8'hD7);
    check_entry("reselect_e7", 3'd7, 8'h4A);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
